// File: rtl/axil_pkg.sv
// axil_pkg: response codes and address decode shared by the AXI-Lite register file.
package axil_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {KIND_CTL, KIND_STS, KIND_ERR} kind_e;
  typedef struct packed {
    kind_e       kind;
    logic [31:0] index;
  } dec_t;
  // index is relative to the start of its own bank (ctl or sts)
  function automatic dec_t addr_decode(input logic [63:0] addr, input int shift,
                                       input int n_ctl, input int n_sts);
    logic [63:0] w;
    dec_t d;
    w = addr >> shift;
    d.kind = KIND_ERR;
    d.index = '0;
    if (w < 64'(n_ctl)) begin
      d.kind = KIND_CTL;
      d.index = w[31:0];
    end else if (w < 64'(n_ctl) + 64'(n_sts)) begin
      d.kind = KIND_STS;
      d.index = 32'(w - 64'(n_ctl));
    end
    return d;
  endfunction
endpackage

// File: rtl/axil_hold.sv
// axil_hold: one-entry valid/ready holding register, emptied by the consumer's pop.
module axil_hold #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic          o_full,
  output logic [DW-1:0] o_data,
  input  logic          i_pop
);
  logic          r_full;
  logic [DW-1:0] r_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_valid && !r_full) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end
  assign o_ready = !r_full;
  assign o_full  = r_full;
  assign o_data  = r_data;
endmodule

// File: rtl/axil_regfile.sv
// axil_regfile: AXI4-Lite control/status register file with byte strobes,
// error responses, self-clearing pulse registers and per-register write strobes.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int               CFGAW       = 32,
  parameter int               CFGDW       = 32,
  parameter int               REGW        = 32,
  parameter int               N_CTL       = 16,
  parameter int               N_STS       = 16,
  parameter int               SIGN_EXTEND = 1,
  parameter logic [REGW-1:0]  CTL_RESET   = '0,
  parameter logic [N_CTL-1:0] PULSE_MASK  = '0
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [CFGAW-1:0]                          s_axil_awaddr,
  input  logic                                      s_axil_awvalid,
  output logic                                      s_axil_awready,
  input  logic [CFGDW-1:0]                          s_axil_wdata,
  input  logic [CFGDW/8-1:0]                        s_axil_wstrb,
  input  logic                                      s_axil_wvalid,
  output logic                                      s_axil_wready,
  output logic [1:0]                                s_axil_bresp,
  output logic                                      s_axil_bvalid,
  input  logic                                      s_axil_bready,
  input  logic [CFGAW-1:0]                          s_axil_araddr,
  input  logic                                      s_axil_arvalid,
  output logic                                      s_axil_arready,
  output logic [CFGDW-1:0]                          s_axil_rdata,
  output logic [1:0]                                s_axil_rresp,
  output logic                                      s_axil_rvalid,
  input  logic                                      s_axil_rready,
  output logic [N_CTL-1:0][REGW-1:0]                ctl_regs,
  output logic [N_CTL-1:0]                          ctl_wstb,
  input  logic [(N_STS > 0 ? N_STS : 1)-1:0][REGW-1:0] sts_regs
);
  localparam int NB = CFGDW / 8;
  localparam int SB = $clog2(NB);

  logic [N_CTL-1:0][REGW-1:0] r_ctl;
  logic [N_CTL-1:0]           r_wstb;
  logic                       r_bvalid, r_rvalid;
  logic [1:0]                 r_bresp, r_rresp;
  logic [CFGDW-1:0]           r_rdata;

  logic             w_aw_full, w_w_full, w_commit, w_ar_hs;
  logic [CFGAW-1:0] w_aw_addr;
  logic [CFGDW-1:0] w_w_data, w_mask;
  logic [NB-1:0]    w_w_strb;
  logic [N_CTL-1:0] w_hit;
  logic [REGW-1:0]  w_rd_val;
  dec_t             w_wdec, w_rdec;

  function automatic logic [CFGDW-1:0] extend(input logic [REGW-1:0] v);
    return (SIGN_EXTEND != 0) ? CFGDW'($signed(v)) : CFGDW'(v);
  endfunction

  axil_hold #(.DW(CFGAW)) u_aw (
    .clk(clk), .rst_n(rst_n),
    .i_data(s_axil_awaddr), .i_valid(s_axil_awvalid), .o_ready(s_axil_awready),
    .o_full(w_aw_full), .o_data(w_aw_addr), .i_pop(w_commit)
  );

  axil_hold #(.DW(CFGDW + NB)) u_w (
    .clk(clk), .rst_n(rst_n),
    .i_data({s_axil_wdata, s_axil_wstrb}), .i_valid(s_axil_wvalid), .o_ready(s_axil_wready),
    .o_full(w_w_full), .o_data({w_w_data, w_w_strb}), .i_pop(w_commit)
  );

  assign w_commit = w_aw_full && w_w_full && (!r_bvalid || s_axil_bready);
  assign w_wdec   = addr_decode(64'(w_aw_addr), SB, N_CTL, N_STS);
  assign w_rdec   = addr_decode(64'(s_axil_araddr), SB, N_CTL, N_STS);

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < NB; b++) w_mask[b*8 +: 8] = {8{w_w_strb[b]}};
  end

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_CTL; i++)
      w_hit[i] = w_commit && w_wdec.kind == KIND_CTL && w_wdec.index == 32'(i);
  end

  // Pulse registers fall back to zero on any cycle they are not being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CTL; i++) r_ctl[i] <= CTL_RESET;
      r_wstb <= '0;
    end else begin
      r_wstb <= w_hit;
      for (int i = 0; i < N_CTL; i++)
        if (w_hit[i])
          r_ctl[i] <= (r_ctl[i] & ~w_mask[REGW-1:0]) | (w_w_data[REGW-1:0] & w_mask[REGW-1:0]);
        else if (PULSE_MASK[i])
          r_ctl[i] <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wdec.kind == KIND_CTL ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axil_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < N_CTL; i++)
      if (w_rdec.kind == KIND_CTL && w_rdec.index == 32'(i)) w_rd_val = r_ctl[i];
    for (int i = 0; i < N_STS; i++)
      if (w_rdec.kind == KIND_STS && w_rdec.index == 32'(i)) w_rd_val = sts_regs[i];
  end

  assign s_axil_arready = !r_rvalid || s_axil_rready;
  assign w_ar_hs        = s_axil_arvalid && s_axil_arready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= extend(w_rd_val);
      r_rresp  <= w_rdec.kind == KIND_ERR ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axil_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_axil_bvalid = r_bvalid;
  assign s_axil_bresp  = r_bresp;
  assign s_axil_rvalid = r_rvalid;
  assign s_axil_rdata  = r_rdata;
  assign s_axil_rresp  = r_rresp;
  assign ctl_regs      = r_ctl;
  assign ctl_wstb      = r_wstb;
endmodule

// File: tb/tb_axil_regfile.sv
// tb_axil_regfile: directed plus randomized checks of axil_regfile against a
// behavioural register/strobe model; two 16-bit instances cover read extension.
module tb_axil_regfile;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [15:0][31:0] ctl_regs, sts32;
  logic [15:0]       ctl_wstb;

  logic [15:0][15:0] sts_n, sx_ctl, zx_ctl;
  logic [15:0]       sx_wstb, zx_wstb;
  logic [31:0]       sx_rdata, zx_rdata;
  logic [1:0]        sx_bresp, zx_bresp, sx_rresp, zx_rresp;
  logic sx_awready, sx_wready, sx_bvalid, sx_arready, sx_rvalid;
  logic zx_awready, zx_wready, zx_bvalid, zx_arready, zx_rvalid;

  axil_regfile #(.PULSE_MASK(16'h0008)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .ctl_regs(ctl_regs), .ctl_wstb(ctl_wstb), .sts_regs(sts32)
  );

  axil_regfile #(.REGW(16), .SIGN_EXTEND(1), .PULSE_MASK(16'h0008)) u_sx (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(sx_awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(sx_wready),
    .s_axil_bresp(sx_bresp), .s_axil_bvalid(sx_bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(sx_arready),
    .s_axil_rdata(sx_rdata), .s_axil_rresp(sx_rresp), .s_axil_rvalid(sx_rvalid), .s_axil_rready(rready),
    .ctl_regs(sx_ctl), .ctl_wstb(sx_wstb), .sts_regs(sts_n)
  );

  axil_regfile #(.REGW(16), .SIGN_EXTEND(0), .PULSE_MASK(16'h0008)) u_zx (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(zx_awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(zx_wready),
    .s_axil_bresp(zx_bresp), .s_axil_bvalid(zx_bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(zx_arready),
    .s_axil_rdata(zx_rdata), .s_axil_rresp(zx_rresp), .s_axil_rvalid(zx_rvalid), .s_axil_rready(rready),
    .ctl_regs(zx_ctl), .ctl_wstb(zx_wstb), .sts_regs(sts_n)
  );

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] model [16];
  int exp_cnt [16];
  int wcnt [16] = '{default: 0};
  logic [15:0][31:0] snap;

  always @(negedge clk)
    for (int i = 0; i < 16; i++) if (ctl_wstb[i]) wcnt[i] <= wcnt[i] + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ctl(input string tag);
    int bad = 0;
    for (int i = 0; i < 16; i++) if (ctl_regs[i] !== model[i]) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  task automatic check_cnt(input string tag);
    int bad = 0;
    for (int i = 0; i < 16; i++) if (wcnt[i] != exp_cnt[i]) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m = old;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
    return m;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    logic ga, gw, got;
    @(posedge clk); #1;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b0;
    for (int n = 0; n < 20 && (awvalid || wvalid); n++) begin
      @(negedge clk);
      ga = awvalid && awready;
      gw = wvalid && wready;
      @(posedge clk); #1;
      if (ga) awvalid = 1'b0;
      if (gw) wvalid = 1'b0;
    end
    chk("wr_accept", {62'd0, awvalid, wvalid}, 64'd0);
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; got = 1'b0; resp = 2'bxx;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (bvalid) begin got = 1'b1; resp = bresp; snap = ctl_regs; end
      @(posedge clk); #1;
    end
    bready = 1'b0;
    chk("wr_bvalid_seen", 64'(got), 64'd1);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] rsp,
                    output logic [31:0] dsx, output logic [31:0] dzx);
    logic g, got;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    for (int n = 0; n < 20 && arvalid; n++) begin
      @(negedge clk);
      g = arready;
      @(posedge clk); #1;
      if (g) arvalid = 1'b0;
    end
    chk("rd_accept", 64'(arvalid), 64'd0);
    arvalid = 1'b0; got = 1'b0; d = 'x; rsp = 'x; dsx = 'x; dzx = 'x;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (rvalid) begin got = 1'b1; d = rdata; rsp = rresp; dsx = sx_rdata; dzx = zx_rdata; end
      @(posedge clk); #1;
    end
    rready = 1'b0;
    chk("rd_rvalid_seen", 64'(got), 64'd1);
  endtask

  initial begin
    logic [1:0]  resp, rsp;
    logic [31:0] d, dsx, dzx, val;
    logic [3:0]  s;
    int idx;
    rst_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      model[i] = '0; exp_cnt[i] = 0; sts32[i] = $urandom; sts_n[i] = 16'($urandom);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_rresp", 64'(rresp), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_wstb", 64'(ctl_wstb), 64'd0);
    check_ctl("rst_ctl");

    // full-word write and readback
    wr(32'h08, 32'h12345678, 4'hF, resp);
    model[2] = 32'h12345678; exp_cnt[2]++;
    chk("w08_bresp", 64'(resp), 64'd0);
    chk("w08_ctl2", 64'(ctl_regs[2]), 64'h12345678);
    check_ctl("w08_all");
    check_cnt("w08_wstb");
    rd(32'h08, d, rsp, dsx, dzx);
    chk("r08_data", 64'(d), 64'h12345678);
    chk("r08_resp", 64'(rsp), 64'd0);

    // partial byte strobes
    wr(32'h04, 32'hAABBCCDD, 4'b0101, resp);
    model[1] = 32'h00BB00DD; exp_cnt[1]++;
    chk("w04_bresp", 64'(resp), 64'd0);
    chk("w04_ctl1", 64'(ctl_regs[1]), 64'h00BB00DD);

    // status read with sign and zero extension
    sts32[0] = 32'hCAFE8001; sts_n[0] = 16'h8001;
    rd(32'h40, d, rsp, dsx, dzx);
    chk("sts0_data32", 64'(d), 64'hCAFE8001);
    chk("sts0_sext", 64'(dsx), 64'hFFFF8001);
    chk("sts0_zext", 64'(dzx), 64'h00008001);
    chk("sts0_resp", 64'(rsp), 64'd0);

    // error writes/reads
    wr(32'h40, 32'hFFFFFFFF, 4'hF, resp);
    chk("wsts_bresp", 64'(resp), 64'd2);
    wr(32'h80, 32'hFFFFFFFF, 4'hF, resp);
    chk("woor_bresp", 64'(resp), 64'd2);
    check_ctl("werr_ctl");
    check_cnt("werr_wstb");
    rd(32'h80, d, rsp, dsx, dzx);
    chk("roor_data", 64'(d), 64'd0);
    chk("roor_resp", 64'(rsp), 64'd2);

    // pulse register: value for one cycle, then zero
    wr(32'h0C, 32'h1, 4'hF, resp);
    exp_cnt[3]++;
    chk("pulse_bresp", 64'(resp), 64'd0);
    chk("pulse_set", 64'(snap[3]), 64'd1);
    chk("pulse_clr", 64'(ctl_regs[3]), 64'd0);
    @(negedge clk);
    chk("pulse_stays_clr", 64'(ctl_regs[3]), 64'd0);
    check_cnt("pulse_wstb");

    // randomized mix against the model
    for (int it = 0; it < 40; it++) begin
      idx = int'($urandom_range(0, 33));
      if ($urandom_range(0, 1) == 1) begin
        val = $urandom; s = 4'($urandom);
        wr(32'(idx * 4 + int'($urandom_range(0, 3))), val, s, resp);
        if (idx < 16) begin
          exp_cnt[idx]++;
          if (idx != 3) model[idx] = merge(model[idx], val, s);
        end
        chk("rnd_bresp", 64'(resp), (idx < 16) ? 64'd0 : 64'd2);
      end else begin
        for (int k = 0; k < 16; k++) sts32[k] = $urandom;
        rd(32'(idx * 4 + int'($urandom_range(0, 3))), d, rsp, dsx, dzx);
        val = (idx < 16) ? model[idx] : (idx < 32) ? sts32[idx - 16] : 32'd0;
        chk("rnd_rdata", 64'(d), 64'(val));
        chk("rnd_rresp", 64'(rsp), (idx < 32) ? 64'd0 : 64'd2);
      end
    end
    check_ctl("rnd_ctl");
    check_cnt("rnd_wstb");

    // W leads AW by three cycles, then B back-pressure and reset mid-stall
    @(posedge clk); #1;
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    chk("st_wready", 64'(wready), 64'd1);
    @(posedge clk); #1 wvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("st_no_b_early", 64'(bvalid), 64'd0);
    end
    @(posedge clk); #1;
    awaddr = 32'h10; awvalid = 1'b1;
    @(negedge clk);
    chk("st_awready", 64'(awready), 64'd1);
    @(posedge clk); #1 awvalid = 1'b0;
    @(posedge clk); #1;
    model[4] = 32'h11223344; exp_cnt[4]++;
    awaddr = 32'h14; awvalid = 1'b1; wdata = 32'h55667788; wvalid = 1'b1;
    @(negedge clk);
    chk("st_bvalid0", 64'(bvalid), 64'd1);
    chk("st_ctl4", 64'(ctl_regs[4]), 64'h11223344);
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("st_bvalid_hold", 64'(bvalid), 64'd1);
      chk("st_bresp_hold", 64'(bresp), 64'd0);
      chk("st_aw_stalled", 64'(awready), 64'd0);
      chk("st_ctl5_unchanged", 64'(ctl_regs[5]), 64'(model[5]));
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("st_rst_bvalid", 64'(bvalid), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1; bready = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (4) begin
      @(negedge clk);
      chk("st_post_bvalid", 64'(bvalid), 64'd0);
      chk("st_post_wstb", 64'(ctl_wstb), 64'd0);
    end
    chk("st_post_awready", 64'(awready), 64'd1);
    check_ctl("st_post_ctl");
    check_cnt("st_post_cnt");
    bready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_regfile.md
Name: axil_regfile

Overview:
- Generalised AXI4-Lite control/status register file.
- Byte-addressed, with per-byte write strobes, error responses, pulse (self-clearing) control registers and per-register write strobes.
- Sits between the AXI-Lite config bus and datapath blocks, replacing the earlier fixed word-addressed register bank.
- Reset is asynchronous, active-low.

Parameters:
- CFGAW, 32: AXI-Lite address width.
- CFGDW, 32: AXI-Lite data width; 32 or 64.
- REGW, 32: register width, 1..CFGDW.
- N_CTL, 16: number of control (RW) registers, ≥1.
- N_STS, 16: number of status (RO) registers, ≥0.
- SIGN_EXTEND, 1: readback of a REGW register to CFGDW is sign-extended if 1, zero-extended if 0.
- CTL_RESET, 0: reset value of every ctl register (low REGW bits used).
- PULSE_MASK, 0: N_CTL-bit mask; bit i=1 makes ctl register i self-clearing.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axil_awaddr  in  CFGAW  write byte address
- s_axil_awvalid  in  1  /  s_axil_awready  out  1
- s_axil_wdata  in  CFGDW  write data
- s_axil_wstrb  in  CFGDW/8  byte strobes
- s_axil_wvalid  in  1  /  s_axil_wready  out  1
- s_axil_bresp  out  2  /  s_axil_bvalid  out  1  /  s_axil_bready  in  1
- s_axil_araddr  in  CFGAW  read byte address
- s_axil_arvalid  in  1  /  s_axil_arready  out  1
- s_axil_rdata  out  CFGDW  /  s_axil_rresp  out  2  /  s_axil_rvalid  out  1  /  s_axil_rready  in  1
- ctl_regs  out  N_CTL x REGW  control register values (registered)
- ctl_wstb  out  N_CTL  one-cycle pulse when ctl register i is written
- sts_regs  in  N_STS x REGW  status inputs, sampled on read

Behaviour:
- Reset (rst_n low, async): awready=wready=arready=1 after release; bvalid=rvalid=0; bresp=rresp=0; rdata=0; ctl_regs=CTL_RESET; ctl_wstb=0; AW/W holding registers empty.
- Address decode: word index = addr >> log2(CFGDW/8); low address bits ignored. Index < N_CTL selects ctl; N_CTL ≤ index < N_CTL+N_STS selects sts; anything else is out of range.
- Write path: independent one-entry AW and W holding registers. awready = !aw_full; wready = !w_full. AW and W may arrive in either order or in the same cycle.
- Commit fires when aw_full && w_full && (!bvalid || bready). On commit both holding registers empty, and bvalid=1 the next cycle. Sustained throughput is one write per 2 cycles.
- Commit to ctl index i: each byte b with wstrb[b]=1 and within REGW updates ctl_regs[i] byte b. ctl_wstb[i]=1 for exactly one cycle, even if all strobes are 0. bresp=OKAY(00).
- Commit to sts index or out of range: no state change, no ctl_wstb, bresp=SLVERR(10).
- Pulse registers (PULSE_MASK[i]=1): the written value is visible for exactly one cycle, then the register returns to 0. Back-to-back commits keep it set.
- B channel: bvalid holds, with bresp stable, until bready. Clear on bready and a new commit in the same cycle keeps bvalid=1 with the new bresp.
- Read path: arready = !rvalid || rready. On AR handshake, rdata/rresp are registered, so rvalid is asserted on the next cycle (latency 1). Full throughput of 1 read per cycle when rready is held high.
- Read data: ctl → ctl_regs value extended per SIGN_EXTEND, rresp=OKAY. sts → sts_regs sampled at the handshake cycle, extended, rresp=OKAY. Out of range → rdata=0, rresp=SLVERR.
- Same-cycle commit and read of the same ctl register returns the old value.
- rst_n asserted mid-transaction: pending AW/W, B and R are discarded; no response is issued for them.

Decomposition:
- Package axil_pkg holds: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and an addr-decode function returning {kind: CTL/STS/ERR, index}.
- One sub-module, axil_hold (one-entry valid/ready holding register, DW parameter), instantiated for AW and for W. The read path is inline.

Test Plan:
- Reset, then write 0x12345678 to addr 0x08 with wstrb=0xF → bresp=00; ctl_regs[2]=0x12345678; ctl_wstb[2] high for 1 cycle; read of 0x08 returns 0x12345678, rresp=00.
- Write 0xAABBCCDD to 0x04 with wstrb=0b0101 over a prior value of 0 → ctl_regs[1]=0x00BB00DD.
- REGW=16, SIGN_EXTEND=1: sts_regs[0]=0x8001, read addr 4*N_CTL → rdata=0xFFFF8001. With SIGN_EXTEND=0 → rdata=0x00008001.
- Write to sts addr and to addr 4*(N_CTL+N_STS) → bresp=10 with ctl unchanged; read of the out-of-range addr → rdata=0, rresp=10.
- PULSE_MASK bit 3 set, write 0x1 to 0x0C → ctl_regs[3]=1 for exactly one cycle, then 0.
- W presented 3 cycles before AW, with bready held low for 5 cycles → one commit, bvalid held with bresp stable, second AW stalled (awready=0) until B drains; assert rst_n mid-stall → bvalid=0 and no commit.
